// File: rtl/timer_clock_gen.sv
// Count-clock generator for two 8-bit TCNT channels: one shared free-running prescaler,
// per-channel clock-select decode, external pin edge detect and cascade, registered enables.
module timer_clock_gen #(
  parameter int CLK_SELECT_BIT_WIDTH = 5,
  parameter int PRESCALER_WIDTH      = 13
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select_0,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select_1,
  input  logic                            TMCI0,
  input  logic                            TMCI1,
  input  logic                            Overflow1,
  input  logic                            CompareMatchA0,
  output logic                            count_en0,
  output logic                            count_en1
);

  logic [PRESCALER_WIDTH-1:0] p;
  logic [7:0]                 tap;
  logic [2:0]                 sync0;
  logic [2:0]                 sync1;
  logic                       rise0, fall0, rise1, fall1;
  logic                       src0, src1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= p + PRESCALER_WIDTH'(1);
    end
  end

  // tap[i] is high for one cycle when the low bits of p are all ones:
  // /2, /8, /32, /64, /128, /256, /1024, /8192
  always_comb begin
    tap    = '0;
    tap[0] = p[0];
    tap[1] = &p[2:0];
    tap[2] = &p[4:0];
    tap[3] = &p[5:0];
    tap[4] = &p[6:0];
    tap[5] = &p[7:0];
    tap[6] = &p[9:0];
    tap[7] = &p[12:0];
  end

  // Two-flop synchronizer plus one history flop; runs regardless of selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[1:0], TMCI0};
      sync1 <= {sync1[1:0], TMCI1};
    end
  end

  assign rise0 = sync0[1] & ~sync0[2];
  assign fall0 = ~sync0[1] & sync0[2];
  assign rise1 = sync1[1] & ~sync1[2];
  assign fall1 = ~sync1[1] & sync1[2];

  function automatic logic select_src(
    input logic [CLK_SELECT_BIT_WIDTH-1:0] sel,
    input logic [7:0]                      taps,
    input logic                            casc,
    input logic                            r,
    input logic                            f
  );
    logic s;
    s = 1'b0;
    case (sel[4:2])
      3'b001:  s = taps[{1'b0, sel[1:0]}];
      3'b010:  s = taps[{1'b1, sel[1:0]}];
      3'b100:  s = casc;
      3'b101:  s = r;
      3'b110:  s = f;
      3'b111:  s = r | f;
      default: s = 1'b0;
    endcase
    return s;
  endfunction

  assign src0 = select_src(clock_select_0, tap, Overflow1, rise0, fall0);
  assign src1 = select_src(clock_select_1, tap, CompareMatchA0, rise1, fall1);

  // Registering the enables breaks the cascade path between the two channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en0 <= 1'b0;
      count_en1 <= 1'b0;
    end else begin
      count_en0 <= src0;
      count_en1 <= src1;
    end
  end

endmodule
